// File: rtl/calc_seq_alu.sv
// calc_seq_alu
//   Multi-cycle signed arithmetic unit for the calculator datapath.
//   Add and sub finish in one cycle. Mul is shift-add and div is restoring,
//   each one bit per cycle, so there is no combinational WIDTH x WIDTH array.
//
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start      request, accepted only while busy=0
//   op         00 add, 01 sub, 10 mul, 11 div (sampled with start)
//   a, b       WIDTH-bit two's-complement operands (sampled with start)
//   busy       high from the accept edge until done drops
//   done       one-cycle pulse; res and flags are valid from this cycle
//   res        2*WIDTH result; for div it is {remainder, quotient}
//   neg        sign of the result (quotient MSB for div)
//   div_zero   the division had a zero divisor
//   ovf        div quotient not representable (-2^(W-1) / -1)
//   state_dbg  current FSM state, for observation only
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// From that edge busy stays high until the cycle after the single done pulse.
// start is ignored whenever busy=1, including the done cycle. Nothing is queued.
// res and the flags hold their values until the next accepted request.
module calc_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res,
  output logic               neg,
  output logic               div_zero,
  output logic               ovf,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      count_q;
  logic               is_div_q;
  logic               sign_q;     // sign of product / quotient
  logic               a_sign_q;   // dividend sign, given to the remainder
  logic [WIDTH-1:0]   mag_b_q;
  // mul: {partial high, multiplier bits still to consume}
  // div: {partial remainder, dividend bits shifting into the quotient}
  logic [2*WIDTH-1:0] acc_q;

  logic               accept;
  logic               short_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] a_ext, b_ext, addsub;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s;
  logic [2*WIDTH-1:0] prod_s;

  assign accept   = start && (state_q == IDLE);
  assign short_op = !op[1] || (op[0] && (b == '0));

  // -2^(W-1) negates to itself, which read as unsigned is the right magnitude.
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  assign a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext  = {{WIDTH{b[WIDTH-1]}}, b};
  assign addsub = op[0] ? (a_ext - b_ext) : (a_ext + b_ext);

  // Shift-add: add the multiplicand into the high half when the LSB is set,
  // then shift the whole register right, carry included.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (acc_q[0] ? mag_b_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: bring the next dividend bit into the remainder and try
  // subtracting the divisor; a borrow (trial MSB) means keep the old value.
  // The remainder is always below the divisor, so its MSB is zero and the
  // plain left shift in the restore case loses nothing.
  assign trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_b_q};
  assign div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign q_mag  = acc_q[WIDTH-1:0];
  assign r_mag  = acc_q[2*WIDTH-1:WIDTH];
  assign q_s    = sign_q   ? -q_mag : q_mag;
  assign r_s    = a_sign_q ? -r_mag : r_mag;
  assign prod_s = sign_q   ? -acc_q : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = short_op ? DONE : CALC;
      CALC: if (count_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      a_sign_q <= 1'b0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      res      <= '0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            res      <= '0;
            neg      <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            is_div_q <= op[0];
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            a_sign_q <= a[WIDTH-1];
            mag_b_q  <= mag_b;
            acc_q    <= {{WIDTH{1'b0}}, mag_a};
            count_q  <= CW'(WIDTH);
            if (!op[1]) begin
              res <= addsub;
              neg <= addsub[2*WIDTH-1];
            end else if (op[0] && (b == '0)) begin
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          acc_q   <= is_div_q ? div_next : mul_next;
          count_q <= count_q - CW'(1);
        end
        FIX: begin
          if (is_div_q) begin
            res <= {r_s, q_s};
            neg <= q_s[WIDTH-1];
            // Magnitude 2^(W-1) with a positive sign only arises for -2^(W-1)/-1.
            ovf <= !sign_q && q_mag[WIDTH-1];
          end else begin
            res <= prod_s;
            neg <= prod_s[2*WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule
